alu_cmd_master: RTL and testbench



---
 rtl/alu_cmd_master.sv | 164 ++++++++++++++++
 tb/tb_alu_cmd_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_master.sv
// alu_cmd_master: APB requester in front of the ALU control slave.
// Commands are buffered in a small FIFO. Each one is packed into the ALU
// instruction word and written to address 16. After a settle delay the
// result register is read back, and one response is returned per command.
// Optional build macro ALU_CMD_MASTER_TIMEOUT_EN adds an ACCESS-phase
// pready timeout. Without it the FSM waits for pready indefinitely.
module alu_cmd_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [1:0]  cmd_shift,
  input  logic [3:0]  cmd_const,
  input  logic [7:0]  cmd_op1,
  input  logic [7:0]  cmd_op2,
  input  logic [5:0]  cmd_addr,
  output logic        rsp_valid,
  output logic [8:0]  rsp_data,
  output logic        rsp_err,
  output logic        alu_state,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_SETUP  = 3'd1;
  localparam logic [2:0] S_WR_ACCESS = 3'd2;
  localparam logic [2:0] S_SETTLE    = 3'd3;
  localparam logic [2:0] S_RD_SETUP  = 3'd4;
  localparam logic [2:0] S_RD_ACCESS = 3'd5;
  localparam logic [2:0] S_RESP      = 3'd6;

  logic [31:0]      fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic [2:0]       state_q, state_d;
  logic [31:0]      word_q;
  logic             err_q;
  logic [8:0]       rdata_q;
  logic [7:0]       settle_q;
  logic [31:0]      cmd_word, head;
  logic             push, pop, head_ok, in_access, tmo_hit;
  logic             wr_phase, rd_phase;
  logic             unused_prdata;

  // The instruction word is packed at push time, so a FIFO entry is the word itself.
  assign cmd_word = {cmd_opcode, cmd_shift, cmd_const, cmd_op2, cmd_op1, cmd_addr};
  assign head     = fifo_q[rd_ptr_q];
  assign head_ok  = (head[31:28] >= 4'd1) && (head[31:28] <= 4'd9) && (head[5:0] <= 6'd15);
  assign push     = cmd_valid && ready_q;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  assign in_access = (state_q == S_WR_ACCESS) || (state_q == S_RD_ACCESS);
  assign unused_prdata = ^prdata[31:9];

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  assign tmo_hit = in_access && !pready && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Count ACCESS cycles spent without pready; cleared outside ACCESS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                tmo_q <= '0;
    else if (in_access && !pready) tmo_q <= tmo_q + 1'b1;
    else                         tmo_q <= '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // FIFO storage and the word of the command in flight; data only, no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= cmd_word;
    if (pop)  word_q <= head;
  end

  // FIFO pointers and occupancy; cmd_ready is registered from the next fill level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
    end
  end

  // Next-state logic for the single-command-in-flight sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (pop) state_d = head_ok ? S_WR_SETUP : S_RESP;
      S_WR_SETUP:  state_d = S_WR_ACCESS;
      S_WR_ACCESS: if (pready) state_d = S_SETTLE;
                   else if (tmo_hit) state_d = S_RESP;
      S_SETTLE:    if (settle_q == 8'(SETTLE_CYCLES - 1)) state_d = S_RD_SETUP;
      S_RD_SETUP:  state_d = S_RD_ACCESS;
      S_RD_ACCESS: if (pready || tmo_hit) state_d = S_RESP;
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State register, settle counter, error flag and captured read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= (state_q == S_SETTLE) ? settle_q + 1'b1 : 8'd0;
      if (pop) begin
        err_q   <= !head_ok;
        rdata_q <= '0;
      end else if (tmo_hit) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end else if ((state_q == S_WR_ACCESS) && pready) begin
        err_q   <= pslverr;
      end else if ((state_q == S_RD_ACCESS) && pready) begin
        err_q   <= err_q | pslverr;
        rdata_q <= prdata[8:0];
      end
    end
  end

  // APB and response outputs decode straight from the state register, so
  // an asynchronous reset drops psel/penable immediately.
  assign wr_phase  = (state_q == S_WR_SETUP) || (state_q == S_WR_ACCESS);
  assign rd_phase  = (state_q == S_RD_SETUP) || (state_q == S_RD_ACCESS);
  assign psel      = wr_phase || rd_phase;
  assign penable   = in_access;
  assign pwrite    = wr_phase;
  assign paddr     = wr_phase ? 32'd16 : (rd_phase ? {26'd0, word_q[5:0]} : 32'd0);
  assign pwdata    = wr_phase ? word_q : 32'd0;
  assign alu_state = psel;
  assign cmd_ready = ready_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = (state_q == S_RESP) && err_q;
  assign rsp_data  = (state_q == S_RESP) ? rdata_q : 9'd0;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Self-checking bench for alu_cmd_master with an APB slave model,
// a protocol monitor and a response scoreboard.
module tb_alu_cmd_master;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_opcode, cmd_const;
  logic [1:0]  cmd_shift;
  logic [7:0]  cmd_op1, cmd_op2;
  logic [5:0]  cmd_addr;
  logic        rsp_valid, rsp_err, alu_state, psel, penable, pwrite;
  logic [8:0]  rsp_data;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  alu_cmd_master dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_shift(cmd_shift), .cmd_const(cmd_const),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_addr(cmd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_state(alu_state), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd_mem [64];
  int   wr_waits, rd_waits, slv_cnt;
  logic wr_err, rd_err, slv_hang;
  logic [9:0]  exp_q [$];
  logic [9:0]  got_q [$];
  logic [63:0] wr_log [$];
  logic [31:0] rd_log [$];
  int   prot_err = 0, psel_cycles = 0, wr_acc_cycles = 0;
  logic prev_psel, prev_penable, prev_pwrite, prev_done;
  logic [31:0] prev_paddr, prev_pwdata;

  // Slave model followed by protocol monitor; pready computed here is what the DUT sees next edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      pready = 1'b0; pslverr = 1'b0; slv_cnt = 0; prev_psel = 1'b0; prev_done = 1'b0;
    end else begin
      logic done;
      if (psel && penable) begin
        if (!slv_hang && slv_cnt >= (pwrite ? wr_waits : rd_waits)) begin
          pready  = 1'b1;
          prdata  = pwrite ? 32'h0 : rd_mem[paddr[5:0]];
          pslverr = pwrite ? wr_err : rd_err;
        end else begin
          pready = 1'b0; pslverr = 1'b0; prdata = 32'hDEAD_BEEF; slv_cnt++;
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0; slv_cnt = 0; prdata = 32'hDEAD_BEEF;
      end
      done = psel && penable && pready;
      if (alu_state !== psel) prot_err++;
      if (!psel && (penable || pwrite || paddr != 0 || pwdata != 0)) prot_err++;
      if (psel) psel_cycles++;
      if (psel && penable && pwrite) wr_acc_cycles++;
      if (prev_psel && !prev_done &&
          (!psel || !penable || paddr !== prev_paddr || pwdata !== prev_pwdata || pwrite !== prev_pwrite))
        prot_err++;
      if (prev_done && psel) prot_err++;
      if (psel && !prev_psel && penable) prot_err++;
      if (done) begin
        if (pwrite) wr_log.push_back({paddr, pwdata});
        else        rd_log.push_back(paddr);
      end
      prev_psel = psel; prev_penable = penable; prev_pwrite = pwrite;
      prev_paddr = paddr; prev_pwdata = pwdata; prev_done = done;
    end
  end

  // Response collector.
  always @(negedge clk) if (reset_n && rsp_valid) got_q.push_back({rsp_err, rsp_data});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got 0 required 1 completion");
    $fatal(1, "watchdog");
  end

  // Offer one command starting at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic [3:0] op, input logic [1:0] sh, input logic [3:0] cn,
                          input logic [7:0] a, input logic [7:0] b, input logic [5:0] ad,
                          output bit ok);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_shift = sh; cmd_const = cn;
    cmd_op1 = a; cmd_op2 = b; cmd_addr = ad;
    for (int i = 0; i < 400 && !cmd_ready; i++) @(negedge clk);
    ok = cmd_ready;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_data, alu_state} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0",
        {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_data, alu_state});
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (psel !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: psel %b rsp_valid %b required 0 0", psel, rsp_valid);
    end
  endtask

  task automatic test_add1();
    bit ok1, ok2;
    int pe0 = prot_err;
    got_q.delete(); exp_q.delete(); wr_log.delete(); rd_log.delete();
    send_cmd(4'd1, 2'd0, 4'd0, 8'h80, 8'h90, 6'd3, ok1);
    exp_q.push_back({1'b0, 9'h110});
    send_cmd(4'd9, 2'd3, 4'd0, 8'h5A, 8'hA5, 6'd15, ok2);
    exp_q.push_back({1'b0, rd_mem[15][8:0]});
    cmd_valid = 1'b0;
    for (int i = 0; i < 200 && got_q.size() < 2; i++) @(posedge clk);
    n_checks++;
    if (!(ok1 && ok2) || got_q.size() != 2) begin
      n_fail++; $display("FAIL add1_count: got %0d responses required 2", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [9:0] g = got_q.pop_front();
      logic [9:0] e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL add1_rsp: got %h required %h", g, e); end
    end
    n_checks++;
    if (wr_log.size() != 2 || wr_log[0] !== {32'd16, 32'h10242003} || wr_log[1] !== {32'd16, 32'h9C29568F}) begin
      n_fail++; $display("FAIL add1_write: got %0d writes first %h required 2 first %h",
        wr_log.size(), wr_log[0], {32'd16, 32'h10242003});
    end
    n_checks++;
    if (rd_log.size() != 2 || rd_log[0] !== 32'd3 || rd_log[1] !== 32'd15) begin
      n_fail++; $display("FAIL add1_read: got %0d reads first %0d required 2 reads 3,15", rd_log.size(), rd_log[0]);
    end
    n_checks++;
    if (prot_err != pe0) begin n_fail++; $display("FAIL add1_protocol: got %0d violations required 0", prot_err - pe0); end
  endtask

  task automatic test_invalid();
    logic [3:0] ops [3] = '{4'hA, 4'h1, 4'h0};
    logic [5:0] ads [3] = '{6'd3, 6'd20, 6'd5};
    for (int c = 0; c < 3; c++) begin
      bit ok;
      int lat = 0;
      int p0 = psel_cycles;
      send_cmd(ops[c], 2'd0, 4'd0, 8'h11, 8'h22, ads[c], ok);
      cmd_valid = 1'b0;
      while (!rsp_valid && lat < 5) begin @(negedge clk); lat++; end
      n_checks++;
      if (!ok || rsp_valid !== 1'b1 || lat > 2) begin
        n_fail++; $display("FAIL invalid_latency[%0d]: got %0d cycles required <=2", c, lat);
      end
      n_checks++;
      if (rsp_err !== 1'b1 || rsp_data !== 9'd0) begin
        n_fail++; $display("FAIL invalid_rsp[%0d]: got err %b data %h required 1 000", c, rsp_err, rsp_data);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (psel_cycles != p0) begin
        n_fail++; $display("FAIL invalid_psel[%0d]: got %0d psel cycles required 0", c, psel_cycles - p0);
      end
    end
    got_q.delete();
  endtask

  task automatic test_wait_err();
    bit ok;
    int pe0 = prot_err;
    int wa0;
    logic [5:0] ads [3] = '{6'd6, 6'd9, 6'd10};
    got_q.delete(); exp_q.delete();
    wr_waits = 3; rd_err = 1'b1; wa0 = wr_acc_cycles;
    send_cmd(4'd2, 2'd1, 4'd0, 8'h11, 8'h22, ads[0], ok);
    cmd_valid = 1'b0;
    exp_q.push_back({1'b1, rd_mem[ads[0]][8:0]});
    for (int i = 0; i < 200 && got_q.size() < 1; i++) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wr_acc_cycles - wa0 != 4) begin
      n_fail++; $display("FAIL wait_access_cycles: got %0d required 4", wr_acc_cycles - wa0);
    end
    wr_waits = 0; rd_err = 1'b0; wr_err = 1'b1;
    send_cmd(4'd3, 2'd0, 4'd0, 8'h33, 8'h44, ads[1], ok);
    cmd_valid = 1'b0;
    exp_q.push_back({1'b1, rd_mem[ads[1]][8:0]});
    for (int i = 0; i < 200 && got_q.size() < 2; i++) @(posedge clk);
    @(negedge clk);
    wr_err = 1'b0;
    send_cmd(4'd4, 2'd0, 4'd0, 8'h55, 8'h66, ads[2], ok);
    cmd_valid = 1'b0;
    exp_q.push_back({1'b0, rd_mem[ads[2]][8:0]});
    for (int i = 0; i < 200 && got_q.size() < 3; i++) @(posedge clk);
    n_checks++;
    if (got_q.size() != 3) begin n_fail++; $display("FAIL wait_count: got %0d responses required 3", got_q.size()); end
    for (int k = 0; k < 3 && got_q.size() > 0; k++) begin
      logic [9:0] g = got_q.pop_front();
      logic [9:0] e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL wait_rsp[%0d]: got %h required %h", k, g, e); end
    end
    n_checks++;
    if (prot_err != pe0) begin n_fail++; $display("FAIL wait_protocol: got %0d violations required 0", prot_err - pe0); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acc = 0;
    int pe0 = prot_err;
    logic [5:0] order [6] = '{6'd7, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4};
    got_q.delete(); exp_q.delete(); rd_log.delete();
    wr_waits = 20;
    for (int k = 0; k < 5; k++) begin
      send_cmd(4'(k + 2), 2'd0, 4'd0, 8'(k), 8'(k * 3), order[k], ok);
      if (ok) acc++;
      exp_q.push_back({1'b0, rd_mem[order[k]][8:0]});
    end
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got cmd_ready %b required 0", cmd_ready); end
    wr_waits = 0;
    send_cmd(4'd7, 2'd0, 4'd0, 8'hEE, 8'hDD, order[5], ok);
    if (ok) acc++;
    exp_q.push_back({1'b0, rd_mem[order[5]][8:0]});
    cmd_valid = 1'b0;
    n_checks++;
    if (acc != 6) begin n_fail++; $display("FAIL b2b_accepts: got %0d required 6", acc); end
    for (int i = 0; i < 600 && got_q.size() < 6; i++) @(posedge clk);
    n_checks++;
    if (got_q.size() != 6) begin n_fail++; $display("FAIL b2b_count: got %0d responses required 6", got_q.size()); end
    for (int k = 0; k < 6 && got_q.size() > 0; k++) begin
      logic [9:0] g = got_q.pop_front();
      logic [9:0] e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got %h required %h", k, g, e); end
      n_checks++;
      if (rd_log.size() <= k || rd_log[k] !== 32'(order[k])) begin
        n_fail++; $display("FAIL b2b_read_addr[%0d]: got %0d required %0d", k, rd_log[k], order[k]);
      end
    end
    n_checks++;
    if (prot_err != pe0) begin n_fail++; $display("FAIL b2b_protocol: got %0d violations required 0", prot_err - pe0); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int i, p0;
    got_q.delete(); exp_q.delete();
    rd_waits = 100000;
    send_cmd(4'd1, 2'd0, 4'd0, 8'h01, 8'h02, 6'd1, ok);
    send_cmd(4'd2, 2'd0, 4'd0, 8'h03, 8'h04, 6'd2, ok);
    send_cmd(4'd3, 2'd0, 4'd0, 8'h05, 8'h06, 6'd4, ok);
    cmd_valid = 1'b0;
    for (i = 0; i < 100 && !(psel && penable && !pwrite); i++) @(negedge clk);
    n_checks++;
    if (!(psel && penable && !pwrite)) begin
      n_fail++; $display("FAIL rstmid_reach: got psel %b penable %b pwrite %b required 1 1 0", psel, penable, pwrite);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: got psel %b penable %b required 0 0", psel, penable);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1; rd_waits = 0;
    p0 = psel_cycles;
    repeat (60) @(negedge clk);
    n_checks++;
    if (got_q.size() != 0 || psel_cycles != p0) begin
      n_fail++; $display("FAIL rstmid_discard: got %0d responses %0d psel cycles required 0 0", got_q.size(), psel_cycles - p0);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b required 1", cmd_ready); end
  endtask

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n = 0;
    got_q.delete();
    slv_hang = 1'b1;
    send_cmd(4'd5, 2'd0, 4'd0, 8'h12, 8'h34, 6'd5, ok);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !psel; i++) @(negedge clk);
    for (int i = 0; i < 100 && psel; i++) begin
      if (penable) n++;
      @(negedge clk);
    end
    n_checks++;
    if (n != 16) begin n_fail++; $display("FAIL timeout_cycles: got %0d required 16", n); end
    for (int i = 0; i < 20 && got_q.size() < 1; i++) @(posedge clk);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, 9'd0}) begin
      n_fail++; $display("FAIL timeout_rsp: got %0d responses first %h required 1 response 200", got_q.size(), got_q[0]);
    end
    slv_hang = 1'b0;
    got_q.delete();
  endtask
`endif

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_shift = '0; cmd_const = '0;
    cmd_op1 = '0; cmd_op2 = '0; cmd_addr = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    wr_waits = 0; rd_waits = 0; wr_err = 1'b0; rd_err = 1'b0; slv_hang = 1'b0;
    for (int i = 0; i < 64; i++) rd_mem[i] = 32'hC0DE_0000 | 32'((i * 29 + 7) % 512);
    rd_mem[3] = 32'hFFFF_F110;
    test_reset();
    test_add1();
    test_invalid();
    test_wait_err();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
